uart_fifo_tx: RTL and testbench

Serial transmitter that drains the 16-deep, 8-bit synchronous FIFO (sfifo) and emits each byte as an 8N1 UART frame on a single line. It is the consumer of the FIFO: it watches `fifo_empty`, issues single-cycle `fifo_rd` pulses, and captures the FIFO's registered read data one cycle later. It sits between the FIFO and the board TX pin.

---
 rtl/uart_fifo_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_fifo_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx
// ------------------------------------------------------------------------
// Drains a 16x8 synchronous FIFO and sends each byte as an 8N1 UART frame
// (one start bit, eight data bits LSB first, one stop bit) on a single line.
//
// Ports
//   CLK         system clock, all logic on the rising edge
//   RSTn        asynchronous active-low reset
//   enable      transmitter may start new frames while high
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after a fifo_rd pulse
//   fifo_rd     FIFO read strobe, one cycle per byte
//   tx          serial line, idle high
//   busy        high in every state except IDLE
//   tx_done     one-cycle pulse after each stop bit completes
//   state_dbg   current FSM state encoding (IDLE=0 .. STOP=5)
//
// FIFO handshake: the FIFO offers a byte whenever fifo_empty is low. This
// block takes it by raising fifo_rd for exactly one cycle, which only
// happens after sampling fifo_empty low in IDLE. The FIFO presents the byte
// on fifo_data at the edge that ends the fifo_rd cycle, and this block
// captures it one cycle after that, in LOAD. There is no back-pressure on
// the read side: a fifo_rd pulse always consumes exactly one byte.
//
// Every output is a flop, so nothing on an input reaches an output in the
// same cycle.
// ------------------------------------------------------------------------
module uart_fifo_tx #(
  parameter int CLK_DIV = 16
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [2:0] state_dbg
);

  // Baud counter width; guard the degenerate clog2 result so the counter is
  // never zero bits wide.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             bit_end;

  // Last cycle of the current serial bit period.
  assign bit_end   = (baud_cnt == CNT_LAST);

  assign state_dbg = state;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift_q  <= 8'h00;
      tx       <= 1'b1;
      fifo_rd  <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      // Single-cycle strobes default low and are raised only on the
      // transition that calls for them.
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;

      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          // enable and fifo_empty are only looked at here, so dropping
          // enable mid-frame lets the current frame run to completion.
          if (enable && !fifo_empty) begin
            state   <= FETCH;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end

        FETCH: begin
          // fifo_rd is high during this cycle; the FIFO updates its read
          // data at the edge that leaves FETCH.
          state <= LOAD;
        end

        LOAD: begin
          shift_q  <= fifo_data;
          tx       <= 1'b0;
          baud_cnt <= '0;
          state    <= START;
        end

        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // tx takes the bit that becomes shift_q[0] after this shift,
              // so the line and the register stay aligned.
              shift_q <= {1'b0, shift_q[7:1]};
              tx      <= shift_q[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            state    <= IDLE;
            baud_cnt <= '0;
            busy     <= 1'b0;
            tx_done  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx with CLK_DIV=4. A small queue-based FIFO model
// feeds the DUT; a line monitor decodes frames and checks them against the
// expected-byte queue filled by the write driver.
module tb_uart_fifo_tx;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] state_dbg;

  uart_fifo_tx #(.CLK_DIV(CLK_DIV)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- FIFO model (registered read data) ----------------
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_flush = 1'b0;
  logic [7:0] fq[$];
  int         fcnt = 0;

  always @(posedge CLK) begin
    if (fifo_flush) begin
      fq.delete();
    end else begin
      if (fifo_rd && fq.size() > 0) fifo_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    fcnt <= fq.size();
  end
  assign fifo_empty = (fcnt == 0);

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int start_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int frames_started = 0;
  int frames_done = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  // ---------------- strobe watcher ----------------
  int rd_pulses = 0;
  int rd_hi = 0;
  int rd_when_empty = 0;
  int done_pulses = 0;
  int last_rd_cyc = -100;
  logic prev_rd = 1'b0;

  always @(negedge CLK) begin
    if (RSTn) begin
      if (fifo_rd) begin
        rd_hi <= rd_hi + 1;
        if (fcnt == 0) rd_when_empty <= rd_when_empty + 1;
        if (!prev_rd) begin
          rd_pulses   <= rd_pulses + 1;
          last_rd_cyc <= cyc;
        end
      end
      if (tx_done) done_pulses <= done_pulses + 1;
    end
    prev_rd <= fifo_rd;
  end

  // ---------------- line monitor ----------------
  initial begin : monitor
    logic       prev_tx;
    logic [9:0] pat;
    logic [7:0] b;
    int         bad;
    int         t0;
    bit         aborted;
    prev_tx = 1'b1;
    forever begin
      @(negedge CLK);
      if (RSTn && prev_tx === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        frames_started++;
        start_q.push_back(t0);
        chk(t0 - last_rd_cyc == 2, "rd_to_start_latency", t0 - last_rd_cyc, 2);
        chk(busy === 1'b1, "busy_in_frame", int'(busy), 1);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_frame", 1, 0);
          b = 8'h00;
        end else begin
          b = exp_q.pop_front();
        end
        pat = {1'b1, b, 1'b0};
        aborted = 1'b0;
        for (int i = 0; i < 10 && !aborted; i++) begin
          bad = 0;
          for (int j = 0; j < CLK_DIV; j++) begin
            if (i > 0 || j > 0) @(negedge CLK);
            if (!RSTn) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== pat[i]) bad++;
          end
          if (!aborted) chk(bad == 0, $sformatf("line_bit%0d_byte%02h", i, b), bad, 0);
        end
        if (!aborted) begin
          @(negedge CLK);
          chk(tx_done === 1'b1, "tx_done_after_stop", int'(tx_done), 1);
          chk(cyc - t0 == FRAME, "tx_done_timing", cyc - t0, FRAME);
          chk(busy === 1'b0, "busy_low_in_idle", int'(busy), 0);
          frames_done++;
        end
      end
      prev_tx = tx;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [7:0] b, input bit expect_tx);
    @(negedge CLK);
    wr_en = 1'b1;
    wr_data = b;
    if (expect_tx) exp_q.push_back(b);
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t;
    t = 0;
    while (frames_done < target && t < budget) begin
      @(negedge CLK);
      t++;
    end
    chk(frames_done >= target, "frame_done_timeout", frames_done, target);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int t;
    t = 0;
    while (frames_started < target && t < budget) begin
      @(negedge CLK);
      t++;
    end
    chk(frames_started >= target, "frame_start_timeout", frames_started, target);
  endtask

  task automatic idle_watch(input int n, input string name);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge CLK);
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk(bad == 0, name, bad, 0);
  endtask

  // ---------------- stimulus ----------------
  int rd0;
  int base;

  initial begin : main
    // Reset state
    repeat (3) @(negedge CLK);
    chk(tx === 1'b1, "reset_tx", int'(tx), 1);
    chk(fifo_rd === 1'b0, "reset_fifo_rd", int'(fifo_rd), 0);
    chk(busy === 1'b0, "reset_busy", int'(busy), 0);
    chk(tx_done === 1'b0, "reset_tx_done", int'(tx_done), 0);
    chk(state_dbg === 3'd0, "reset_state", int'(state_dbg), 0);
    RSTn = 1'b1;

    // 1: idle with empty FIFO and enable high
    enable = 1'b1;
    idle_watch(20, "idle_empty_quiet");

    // 2: single byte 0xA5
    rd0 = rd_pulses;
    base = frames_done;
    wr(8'hA5, 1'b1);
    wait_frames(base + 1, 100);
    repeat (5) @(negedge CLK);
    chk(rd_pulses - rd0 == 1, "a5_rd_pulses", rd_pulses - rd0, 1);

    // 3: three bytes back to back
    enable = 1'b0;
    start_q.delete();
    rd0 = rd_pulses;
    base = frames_done;
    wr(8'h00, 1'b1);
    wr(8'hFF, 1'b1);
    wr(8'h55, 1'b1);
    enable = 1'b1;
    wait_frames(base + 3, 300);
    repeat (5) @(negedge CLK);
    chk(rd_pulses - rd0 == 3, "b2b_rd_pulses", rd_pulses - rd0, 3);
    chk(start_q.size() == 3, "b2b_start_count", start_q.size(), 3);
    if (start_q.size() == 3) begin
      chk(start_q[1] - start_q[0] == FRAME + 3, "b2b_spacing_1", start_q[1] - start_q[0], FRAME + 3);
      chk(start_q[2] - start_q[1] == FRAME + 3, "b2b_spacing_2", start_q[2] - start_q[1], FRAME + 3);
    end
    chk(fifo_empty === 1'b1, "b2b_fifo_empty", int'(fifo_empty), 1);

    // 4: byte held back by enable=0
    enable = 1'b0;
    rd0 = rd_pulses;
    base = frames_done;
    wr(8'h3C, 1'b1);
    idle_watch(50, "disabled_quiet");
    chk(rd_pulses == rd0, "disabled_no_rd", rd_pulses - rd0, 0);
    enable = 1'b1;
    wait_frames(base + 1, 100);
    repeat (5) @(negedge CLK);
    chk(rd_pulses - rd0 == 1, "enable_3c_rd", rd_pulses - rd0, 1);

    // 5: enable dropped during data bit 3 of the first of two frames
    enable = 1'b0;
    rd0 = rd_pulses;
    base = frames_done;
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b0);
    enable = 1'b1;
    wait_starts(frames_started + 1, 50);
    repeat (4 * CLK_DIV + 1) @(negedge CLK);
    enable = 1'b0;
    wait_frames(base + 1, 100);
    repeat (60) @(negedge CLK);
    chk(rd_pulses - rd0 == 1, "drop_en_rd_pulses", rd_pulses - rd0, 1);
    chk(fcnt == 1, "drop_en_byte_kept", fcnt, 1);
    chk(frames_started == base + 1 + (frames_started - frames_done), "drop_en_no_extra_start", frames_started - frames_done, 0);
    @(negedge CLK);
    fifo_flush = 1'b1;
    @(negedge CLK);
    fifo_flush = 1'b0;

    // 6: reset during data bit 5 of 0x81, then a clean 0x42
    enable = 1'b1;
    wr(8'h81, 1'b1);
    wait_starts(frames_started + 1, 50);
    repeat (6 * CLK_DIV + 1) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk(tx === 1'b1, "midframe_reset_tx", int'(tx), 1);
    chk(busy === 1'b0, "midframe_reset_busy", int'(busy), 0);
    chk(state_dbg === 3'd0, "midframe_reset_state", int'(state_dbg), 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    base = frames_done;
    rd0 = rd_pulses;
    wr(8'h42, 1'b1);
    wait_frames(base + 1, 100);
    repeat (5) @(negedge CLK);
    chk(rd_pulses - rd0 == 1, "after_reset_rd", rd_pulses - rd0, 1);

    // End-of-run bookkeeping
    chk(exp_q.size() == 0, "expected_queue_drained", exp_q.size(), 0);
    chk(rd_when_empty == 0, "rd_never_when_empty", rd_when_empty, 0);
    chk(rd_hi == rd_pulses, "rd_single_cycle", rd_hi, rd_pulses);
    chk(done_pulses == frames_done, "tx_done_pulse_count", done_pulses, frames_done);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
